// File: rtl/calc1_pkg.sv
// Shared encodings, FSM state and request-entry layout for the calc1 port driver.
package calc1_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;
  localparam logic [RESP_W-1:0] RESP_IERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND1,
    ST_SEND2,
    ST_WAIT,
    ST_HOLD
  } drv_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_entry_t;

  localparam int REQ_W = $bits(req_entry_t);

endpackage

// File: rtl/calc1_req_fifo.sv
// Synchronous request FIFO; pointers wrap naturally because DEPTH is a power of two.
module calc1_req_fifo
  import calc1_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = REQ_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  assign rdata = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/calc1_port_driver.sv
// Request-side transactor for one calc1 port: queues requests, serialises them
// into the two-cycle command/data protocol and returns one response at a time.
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  output logic [CMD_W-1:0]  calc_cmd,
  output logic [DATA_W-1:0] calc_data,
  input  logic [RESP_W-1:0] calc_resp,
  input  logic [DATA_W-1:0] calc_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RESP_W-1:0] rsp_code,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout
);

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  drv_state_e        state_q, state_d;
  req_entry_t        head, push_entry;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              ready_q, ready_d;
  logic              resp_seen, timed_out;
  logic [CMD_W-1:0]  calc_cmd_q, calc_cmd_d;
  logic [DATA_W-1:0] calc_data_q, calc_data_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RESP_W-1:0] rsp_code_q, rsp_code_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  // ready_q holds req_ready low until the cycle after reset is released.
  assign ready_d    = 1'b1;
  assign req_ready  = ready_q && !fifo_full;
  assign fifo_push  = req_valid && req_ready;
  assign push_entry = '{cmd: req_cmd, op1: req_op1, op2: req_op2};

  calc1_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REQ_W)
  ) u_fifo (
    .clk   (c_clk),
    .rst   (reset),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = (head.cmd == CMD_NOP) ? ST_HOLD : ST_SEND1;
      ST_SEND1: state_d = ST_SEND2;
      ST_SEND2: state_d = ST_WAIT;
      ST_WAIT:  if (resp_seen || timed_out) state_d = ST_HOLD;
      ST_HOLD:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Responses outside WAIT are strays and never decoded.
  always_comb begin
    fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    rsp_valid = (state_q == ST_HOLD);
    resp_seen = (state_q == ST_WAIT) && (calc_resp != RESP_NONE);
    timed_out = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
  end

  always_comb begin
    calc_cmd_d    = calc_cmd_q;
    calc_data_d   = calc_data_q;
    op2_d         = op2_q;
    cnt_d         = cnt_q;
    rsp_code_d    = rsp_code_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head.cmd == CMD_NOP) begin
            rsp_code_d    = RESP_ERR;
            rsp_data_d    = '0;
            rsp_timeout_d = 1'b0;
          end else begin
            calc_cmd_d  = head.cmd;
            calc_data_d = head.op1;
            op2_d       = head.op2;
          end
        end
      end
      ST_SEND1: begin
        calc_cmd_d  = CMD_NOP;
        calc_data_d = op2_q;
      end
      ST_SEND2: begin
        calc_cmd_d  = CMD_NOP;
        calc_data_d = '0;
        cnt_d       = '0;
      end
      ST_WAIT: begin
        if (resp_seen) begin
          rsp_code_d    = calc_resp;
          rsp_data_d    = calc_rdata;
          rsp_timeout_d = 1'b0;
        end else if (timed_out) begin
          rsp_code_d    = RESP_NONE;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Every externally visible register is cleared by reset.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      calc_cmd_q    <= '0;
      calc_data_q   <= '0;
      rsp_code_q    <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      calc_cmd_q    <= calc_cmd_d;
      calc_data_q   <= calc_data_d;
      rsp_code_q    <= rsp_code_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_ff @(posedge c_clk) begin
    op2_q <= op2_d;
    cnt_q <= cnt_d;
  end

  assign calc_cmd    = calc_cmd_q;
  assign calc_data   = calc_data_q;
  assign rsp_code    = rsp_code_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Bench for calc1_port_driver: the bench plays calc1 and checks bus framing,
// latency, ordering, back-pressure, timeout and reset behaviour.
module tb_calc1_port_driver;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 32;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [3:0]  calc_cmd;
  logic [31:0] calc_data;
  logic [1:0]  calc_resp;
  logic [31:0] calc_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_data;
  logic        rsp_timeout;

  always #5 c_clk = ~c_clk;

  calc1_port_driver #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
    .calc_cmd(calc_cmd), .calc_data(calc_data),
    .calc_resp(calc_resp), .calc_rdata(calc_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_code(rsp_code), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
  );

  typedef struct { logic [3:0] cmd; logic [31:0] op1; logic [31:0] op2; } req_t;
  typedef struct { logic [3:0] cmd1; logic [31:0] d1; logic [3:0] cmd2; logic [31:0] d2; } bus_t;

  req_t       exp_q[$];
  bus_t       bus_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] cmd_tbl [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd15};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // calc1 behaviour: {resp, data}; overflow, underflow and unknown codes are errors.
  function automatic logic [33:0] calc_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (c)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        calc_ref = s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
      end
      4'd2:    calc_ref = (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5:    calc_ref = {2'd1, a << b[4:0]};
      4'd6:    calc_ref = {2'd1, a >> b[4:0]};
      default: calc_ref = {2'd2, 32'd0};
    endcase
  endfunction

  // Records every command/data pair framed on the calc1 bus.
  initial begin
    bus_t r;
    forever begin
      @(negedge c_clk);
      if (!reset && calc_cmd !== 4'd0) begin
        r.cmd1 = calc_cmd;
        r.d1   = calc_data;
        @(negedge c_clk);
        r.cmd2 = calc_cmd;
        r.d2   = calc_data;
        bus_q.push_back(r);
      end
    end
  end

  task automatic push(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output bit acc);
    @(negedge c_clk);
    req_valid = 1'b1;
    req_cmd   = c;
    req_op1   = a;
    req_op2   = b;
    acc       = req_ready;
    @(posedge c_clk);
    #1;
    req_valid = 1'b0;
    if (acc) exp_q.push_back('{cmd: c, op1: a, op2: b});
  endtask

  // Serves the oldest outstanding request as calc1 would, then checks and accepts the response.
  task automatic serve(input int delay, input bit stray);
    req_t        e;
    bus_t        b;
    logic [33:0] stub_r, exp_r;
    logic [1:0]  held_code;
    logic [31:0] held_data;
    int          n;
    @(negedge c_clk);
    e     = exp_q.pop_front();
    exp_r = (e.cmd == 4'd0) ? {2'd2, 32'd0} : calc_ref(e.cmd, e.op1, e.op2);
    if (e.cmd != 4'd0) begin
      n = 0;
      while (bus_q.size() == 0 && n < 40) begin
        @(negedge c_clk);
        n++;
      end
      check("bus_seen", 32'(bus_q.size() != 0), 32'd1);
      if (bus_q.size() == 0) return;
      b = bus_q.pop_front();
      check("bus_cmd1", 32'(b.cmd1), 32'(e.cmd));
      check("bus_op1", b.d1, e.op1);
      check("bus_cmd2", 32'(b.cmd2), 32'd0);
      check("bus_op2", b.d2, e.op2);
      @(negedge c_clk);
      for (int i = 0; i < delay; i++) begin
        check("early_valid", 32'(rsp_valid), 32'd0);
        @(negedge c_clk);
      end
      stub_r     = calc_ref(b.cmd1, b.d1, b.d2);
      calc_resp  = stub_r[33:32];
      calc_rdata = stub_r[31:0];
      @(negedge c_clk);
      calc_resp  = 2'd0;
      calc_rdata = $urandom;
    end else begin
      n = 0;
      while (!rsp_valid && n < 10) begin
        @(negedge c_clk);
        n++;
      end
      check("nop_bus_quiet", 32'(bus_q.size()), 32'd0);
      check("nop_calc_cmd", 32'(calc_cmd), 32'd0);
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_code", 32'(rsp_code), 32'(exp_r[33:32]));
    check("rsp_data", rsp_data, exp_r[31:0]);
    check("rsp_timeout", 32'(rsp_timeout), 32'd0);
    if (stray) begin
      held_code  = rsp_code;
      held_data  = rsp_data;
      calc_resp  = 2'd3;
      calc_rdata = $urandom;
      @(negedge c_clk);
      calc_resp  = 2'd0;
      check("hold_code", 32'(rsp_code), 32'(held_code));
      check("hold_data", rsp_data, held_data);
      check("hold_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge c_clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_released", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          acc;
    logic [3:0]  c;
    logic [31:0] a, b;
    int          burst;
    logic [3:0]  bp_cmds [5] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd0};

    reset = 1'b1; req_valid = 1'b0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
    calc_resp = '0; calc_rdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge c_clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_calc_cmd", 32'(calc_cmd), 32'd0);
    check("rst_calc_data", calc_data, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_code", 32'(rsp_code), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge c_clk);
    reset = 1'b0;
    @(posedge c_clk);
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);
    bus_q.delete();

    // Add with latency of the command/data framing
    push(4'd1, 32'h0000_0001, 32'h01FF_FFFF, acc);
    check("add_acc", 32'(acc), 32'd1);
    check("add_lat_t0", 32'(calc_cmd), 32'd0);
    @(posedge c_clk); #1;
    check("add_lat_cmd", 32'(calc_cmd), 32'd1);
    check("add_lat_op1", calc_data, 32'h0000_0001);
    @(posedge c_clk); #1;
    check("add_lat_cmd0", 32'(calc_cmd), 32'd0);
    check("add_lat_op2", calc_data, 32'h01FF_FFFF);
    @(posedge c_clk); #1;
    check("add_lat_idle", calc_data, 32'd0);
    serve(0, 1'b0);
    check("add_code", 32'(rsp_code), 32'd1);
    check("add_data", rsp_data, 32'h0200_0000);

    // cmd 0 is answered locally one cycle after the pop
    push(4'd0, $urandom, $urandom, acc);
    check("nop_early", 32'(rsp_valid), 32'd0);
    @(posedge c_clk); #1;
    check("nop_valid", 32'(rsp_valid), 32'd1);
    check("nop_cmd", 32'(calc_cmd), 32'd0);
    check("nop_code", 32'(rsp_code), 32'd2);
    check("nop_data", rsp_data, 32'd0);
    serve(0, 1'b1);

    // Overflow and underflow
    push(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, acc);
    serve(1, 1'b0);
    check("ovf_code", 32'(rsp_code), 32'd2);
    push(4'd2, 32'h0000_0001, 32'h0000_000F, acc);
    serve(2, 1'b1);
    check("udf_code", 32'(rsp_code), 32'd2);

    // Back-pressure: one request in flight plus a full FIFO
    for (int i = 0; i < 6; i++) begin
      c = (i < 5) ? bp_cmds[i] : 4'd3;
      push(c, $urandom, $urandom & 32'hFF, acc);
      check("bp_accept", 32'(acc), (i < 5) ? 32'd1 : 32'd0);
    end
    serve($urandom_range(0, 3), 1'b0);
    check("bp_still_full", 32'(req_ready), 32'd0);
    @(posedge c_clk); #1;
    check("bp_space_freed", 32'(req_ready), 32'd1);
    for (int i = 1; i < 5; i++) serve($urandom_range(0, 3), 1'(i % 2));

    // Timeout with a silent calc1
    push(4'd5, $urandom, 32'd3, acc);
    repeat (3) @(posedge c_clk);
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge c_clk); #1;
      if (i < TIMEOUT) check("to_wait", 32'(rsp_valid), 32'd0);
    end
    check("to_valid", 32'(rsp_valid), 32'd1);
    check("to_flag", 32'(rsp_timeout), 32'd1);
    check("to_code", 32'(rsp_code), 32'd0);
    check("to_data", rsp_data, 32'd0);
    check("to_bus_seen", 32'(bus_q.size()), 32'd1);
    void'(exp_q.pop_front());
    bus_q.delete();
    rsp_ready = 1'b1;
    @(posedge c_clk); #1;
    rsp_ready = 1'b0;
    check("to_released", 32'(rsp_valid), 32'd0);

    // Randomised bursts of up to three requests
    for (int it = 0; it < 14; it++) begin
      burst = $urandom_range(1, 3);
      for (int k = 0; k < burst; k++) begin
        c = cmd_tbl[$urandom_range(0, 6)];
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFF);
        push(c, a, b, acc);
        check("rnd_accept", 32'(acc), 32'd1);
      end
      for (int k = 0; k < burst; k++) serve($urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // Reset while waiting, with further requests queued
    push(4'd1, 32'd10, 32'd20, acc);
    serve(0, 1'b0);
    push(4'd6, 32'h8000_0000, 32'd4, acc);
    push(4'd1, 32'd3, 32'd4, acc);
    push(4'd2, 32'd9, 32'd1, acc);
    @(posedge c_clk);
    @(negedge c_clk);
    reset = 1'b1;
    @(posedge c_clk); #1;
    check("rw_req_ready", 32'(req_ready), 32'd0);
    check("rw_calc_cmd", 32'(calc_cmd), 32'd0);
    check("rw_calc_data", calc_data, 32'd0);
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw_rsp_code", 32'(rsp_code), 32'd0);
    check("rw_rsp_data", rsp_data, 32'd0);
    check("rw_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge c_clk);
    reset      = 1'b0;
    calc_resp  = 2'd1;
    calc_rdata = 32'hDEAD_BEEF;
    @(posedge c_clk); #1;
    check("rw_ready_back", 32'(req_ready), 32'd1);
    @(negedge c_clk);
    calc_resp = 2'd0;
    for (int i = 0; i < 6; i++) begin
      @(posedge c_clk); #1;
      check("rw_no_valid", 32'(rsp_valid), 32'd0);
      check("rw_no_send", 32'(calc_cmd), 32'd0);
    end
    exp_q.delete();
    bus_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
